// File: rtl/fxp_product_accumulator.sv
// rtl/fxp_product_accumulator.sv - sums runs of signed fixed-point products into one n-bit result.
// Optional clamp-on-overflow output selected by the FXP_ACC_SATURATE_EN macro.
module fxp_product_accumulator #(
  parameter int n     = 32,
  parameter int d     = 16,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             recv_val,
  output logic             recv_rdy,
  input  logic [n-1:0]     recv_msg,
  output logic             send_val,
  input  logic             send_rdy,
  output logic [n-1:0]     send_msg,
  output logic             send_ovf
);

  localparam int AW = n + LEN_W;

  // The binary point is carried through untouched; d only has to describe a valid Q format.
  if (d < 0 || d >= n) begin : g_bad_frac
    $error("fxp_product_accumulator: d must lie in [0, n)");
  end

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t                 r_state, w_state_next;
  logic signed [AW-1:0]   r_acc, w_acc_next, w_prod_ext;
  logic [LEN_W-1:0]       r_cnt, w_cnt_next;
  logic [LEN_W-1:0]       r_len, w_len_next, w_len_eff;
  logic [n-1:0]           r_send_msg, w_result_msg;
  logic                   r_send_ovf;
  logic                   w_recv_fire, w_send_fire, w_done_entry, w_fits;
  logic [LEN_W:0]         w_top_bits;

  assign recv_rdy    = (r_state != DONE);
  assign send_val    = (r_state == DONE);
  assign send_msg    = r_send_msg;
  assign send_ovf    = r_send_ovf;
  assign w_recv_fire = recv_val & recv_rdy;
  assign w_send_fire = send_val & send_rdy;
  assign w_prod_ext  = {{LEN_W{recv_msg[n-1]}}, recv_msg};
  assign w_len_eff   = (cfg_len == '0) ? LEN_W'(1) : cfg_len;

  always_comb begin
    w_state_next = r_state;
    w_acc_next   = r_acc;
    w_cnt_next   = r_cnt;
    w_len_next   = r_len;
    case (r_state)
      IDLE: begin
        if (w_recv_fire) begin
          w_len_next   = w_len_eff;
          w_acc_next   = w_prod_ext;
          w_cnt_next   = LEN_W'(1);
          w_state_next = (w_len_eff == LEN_W'(1)) ? DONE : ACC;
        end
      end
      ACC: begin
        if (w_recv_fire) begin
          w_acc_next = r_acc + w_prod_ext;
          w_cnt_next = r_cnt + LEN_W'(1);
          if (r_cnt + LEN_W'(1) == r_len) w_state_next = DONE;
        end
      end
      DONE: begin
        if (w_send_fire) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // The result is formed from the sum being written on the edge that enters DONE.
  assign w_done_entry = (w_state_next == DONE) && (r_state != DONE);
  assign w_top_bits   = w_acc_next[AW-1:n-1];
  assign w_fits       = (&w_top_bits) | ~(|w_top_bits);

`ifdef FXP_ACC_SATURATE_EN
  always_comb begin
    w_result_msg = w_acc_next[n-1:0];
    if (!w_fits) begin
      w_result_msg = w_acc_next[AW-1] ? {1'b1, {(n-1){1'b0}}} : {1'b0, {(n-1){1'b1}}};
    end
  end
`else
  always_comb begin
    w_result_msg = w_acc_next[n-1:0];
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_len      <= '0;
      r_send_msg <= '0;
      r_send_ovf <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_acc   <= w_acc_next;
      r_cnt   <= w_cnt_next;
      r_len   <= w_len_next;
      if (w_done_entry) begin
        r_send_msg <= w_result_msg;
        r_send_ovf <= ~w_fits;
      end
    end
  end

endmodule

// File: tb/tb_fxp_product_accumulator.sv
// tb/tb_fxp_product_accumulator.sv - self-checking bench for fxp_product_accumulator.
module tb_fxp_product_accumulator;

  localparam int N  = 32;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [LW-1:0] cfg_len;
  logic          recv_val;
  logic          recv_rdy;
  logic [N-1:0]  recv_msg;
  logic          send_val;
  logic          send_rdy;
  logic [N-1:0]  send_msg;
  logic          send_ovf;

  int checks = 0;
  int errors = 0;

  fxp_product_accumulator #(.n(N), .d(16), .LEN_W(LW)) dut (
    .clk(clk), .reset(reset), .cfg_len(cfg_len),
    .recv_val(recv_val), .recv_rdy(recv_rdy), .recv_msg(recv_msg),
    .send_val(send_val), .send_rdy(send_rdy), .send_msg(send_msg), .send_ovf(send_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic [7:0]  len;
    int          np;
    logic [31:0] p [4];
    int          gap;
    int          hold;
    logic [31:0] exp_msg;
    logic        exp_ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference rule: exact integer sum, overflow when it leaves the n-bit signed range.
  task automatic model(input longint s, output logic [31:0] m, output logic o);
    longint t;
    t = s;
    o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    m = t[31:0];
`ifdef FXP_ACC_SATURATE_EN
    if (o) m = (s < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
  endtask

  task automatic push(input logic [31:0] m, input logic [7:0] len, input int gap);
    int t;
    recv_val = 1'b0;
    repeat (gap) @(negedge clk);
    recv_val = 1'b1;
    recv_msg = m;
    cfg_len  = len;
    t = 0;
    while (!recv_rdy && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!recv_rdy) begin
      checks++;
      errors++;
      $display("FAIL push_wait actual=recv_rdy_low required=recv_rdy_high");
    end
    @(negedge clk);
    recv_val = 1'b0;
  endtask

  task automatic collect(input string name, input logic [31:0] em, input logic eo, input int hold);
    int t;
    t = 0;
    while (!send_val && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_val"}, {31'd0, send_val}, 32'd1);
    chk({name, "_msg"}, send_msg, em);
    chk({name, "_ovf"}, {31'd0, send_ovf}, {31'd0, eo});
    repeat (hold) begin
      @(negedge clk);
      chk({name, "_hold_msg"}, send_msg, em);
      chk({name, "_hold_val"}, {31'd0, send_val}, 32'd1);
      chk({name, "_hold_rdy"}, {31'd0, recv_rdy}, 32'd0);
    end
    send_rdy = 1'b1;
    @(negedge clk);
    send_rdy = 1'b0;
    chk({name, "_idle_val"}, {31'd0, send_val}, 32'd0);
    chk({name, "_idle_rdy"}, {31'd0, recv_rdy}, 32'd1);
  endtask

  vec_t vecs [6];

  initial begin
    vecs[0] = '{"basic", 8'd2, 2, '{32'h0001_8000, 32'h0002_4000, 32'h0, 32'h0}, 0, 0, 32'h0003_C000, 1'b0};
    vecs[1] = '{"signed", 8'd3, 3, '{32'hFFFF_0000, 32'hFFFF_8000, 32'h0001_0000, 32'h0}, 0, 1, 32'hFFFF_8000, 1'b0};
`ifdef FXP_ACC_SATURATE_EN
    vecs[2] = '{"ovf_pos", 8'd2, 2, '{32'h7FFF_0000, 32'h7FFF_0000, 32'h0, 32'h0}, 0, 1, 32'h7FFF_FFFF, 1'b1};
    vecs[5] = '{"ovf_neg", 8'd2, 2, '{32'h8000_0000, 32'h8000_0000, 32'h0, 32'h0}, 1, 0, 32'h8000_0000, 1'b1};
`else
    vecs[2] = '{"ovf_pos", 8'd2, 2, '{32'h7FFF_0000, 32'h7FFF_0000, 32'h0, 32'h0}, 0, 1, 32'hFFFE_0000, 1'b1};
    vecs[5] = '{"ovf_neg", 8'd2, 2, '{32'h8000_0000, 32'h8000_0000, 32'h0, 32'h0}, 1, 0, 32'h0000_0000, 1'b1};
`endif
    vecs[3] = '{"zero_len", 8'd0, 1, '{32'h0005_0000, 32'h0, 32'h0, 32'h0}, 0, 5, 32'h0005_0000, 1'b0};
    vecs[4] = '{"gapped", 8'd4, 4, '{32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000}, 2, 0, 32'h000A_0000, 1'b0};

    reset    = 1'b1;
    cfg_len  = '0;
    recv_val = 1'b0;
    recv_msg = '0;
    send_rdy = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_send_val", {31'd0, send_val}, 32'd0);
    chk("rst_send_msg", send_msg, 32'd0);
    chk("rst_send_ovf", {31'd0, send_ovf}, 32'd0);
    chk("rst_recv_rdy", {31'd0, recv_rdy}, 32'd1);

    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < vecs[i].np; k++) push(vecs[i].p[k], vecs[i].len, vecs[i].gap);
      chk({vecs[i].name, "_latency"}, {31'd0, send_val}, 32'd1);
      collect(vecs[i].name, vecs[i].exp_msg, vecs[i].exp_ovf, vecs[i].hold);
    end

    // Product offered during DONE must wait for the send fire, then be taken in IDLE.
    cfg_len  = 8'd1;
    recv_val = 1'b1;
    recv_msg = 32'h0007_0000;
    @(negedge clk);
    recv_msg = 32'h0002_0000;
    repeat (3) begin
      @(negedge clk);
      chk("done_stall_msg", send_msg, 32'h0007_0000);
      chk("done_stall_rdy", {31'd0, recv_rdy}, 32'd0);
    end
    send_rdy = 1'b1;
    @(negedge clk);
    send_rdy = 1'b0;
    chk("done_release_val", {31'd0, send_val}, 32'd0);
    @(negedge clk);
    recv_val = 1'b0;
    chk("done_next_val", {31'd0, send_val}, 32'd1);
    chk("done_next_msg", send_msg, 32'h0002_0000);
    send_rdy = 1'b1;
    @(negedge clk);
    send_rdy = 1'b0;

    // Reset mid-run, then reset with a pending result.
    push(32'h0009_0000, 8'd4, 0);
    push(32'h0009_0000, 8'd4, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_val", {31'd0, send_val}, 32'd0);
    chk("midrst_rdy", {31'd0, recv_rdy}, 32'd1);
    push(32'h0000_0123, 8'd1, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("donerst_val", {31'd0, send_val}, 32'd0);
    chk("donerst_msg", send_msg, 32'd0);
    push(32'h0001_0000, 8'd1, 0);
    collect("after_rst", 32'h0001_0000, 1'b0, 0);

    for (int r = 0; r < 40; r++) begin
      int          len, cnt, mode;
      longint      sum;
      logic [31:0] p, em;
      logic        eo;
      len = $urandom_range(0, 6);
      cnt = (len == 0) ? 1 : len;
      sum = 0;
      for (int k = 0; k < cnt; k++) begin
        mode = $urandom_range(0, 3);
        case (mode)
          0:       p = $urandom;
          1:       p = 32'h7FFF_0000 | ($urandom & 32'h0000_FFFF);
          2:       p = 32'h8000_0000 | ($urandom & 32'h0000_FFFF);
          default: p = 32'($urandom_range(0, 255)) << 16;
        endcase
        sum += longint'($signed(p));
        push(p, (k == 0) ? 8'(len) : 8'($urandom_range(0, 255)), $urandom_range(0, 2));
      end
      model(sum, em, eo);
      chk("rand_latency", {31'd0, send_val}, 32'd1);
      collect("rand", em, eo, $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
